// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and limits for the multicycle MIPS memory responder.
//   state_e         : responder FSM state encoding
//   op_e            : latched request operation
//   MAX_WAIT_CYCLES : largest legal WAIT_CYCLES value
//   CNT_W           : width of the wait-state counter
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10
    } op_e;

    localparam int unsigned MAX_WAIT_CYCLES = 15;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mips_mem_array.sv
// mips_mem_array: 2**ADDR_W x 32 word storage, synchronous write, combinational read.
// Contents are not reset.
//   clk   in  clock
//   we    in  write enable, sampled on the rising edge
//   idx   in  word index shared by the read and write port
//   wdata in  write data
//   rdata out combinational read data of mem[idx]
module mips_mem_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: services MemRead/MemWrite strobes of the multicycle MIPS controller
// against a unified word memory, inserting WAIT_CYCLES wait states and answering each
// access with a one-cycle mem_ready pulse.
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_read, mem_write request strobes, held until mem_ready
//   addr                byte address; word index is addr[ADDR_W+1:2]
//   wdata               write data
//   rdata               registered read data, held until the next read commit
//   mem_ready           one-cycle completion pulse (RESP)
//   mem_err             error pulse with mem_ready (read/write conflict, or misalignment)
//   busy                high in WAIT and RESP
// Build option: define MIPS_MEM_ALIGN_CHECK_EN to reject accesses with addr[1:0] != 0.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    if (WAIT_CYCLES > MAX_WAIT_CYCLES) begin : gen_wait_cycles_check
        $error("mips_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    localparam int unsigned WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [31:0]        rdata_q;

    logic               req;
    logic               misalign;
    logic               acc_err;
    op_e                acc_op;
    logic               accept;
    logic               commit;
    op_e                cmt_op;
    logic [ADDR_W-1:0]  cmt_idx;
    logic [31:0]        cmt_wdata;
    logic [31:0]        arr_rdata;
    logic               unused_addr;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign misalign = (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign req     = mem_read | mem_write;
    assign acc_err = (mem_read & mem_write) | misalign;
    assign acc_op  = acc_err   ? OP_NONE :
                     mem_read  ? OP_RD   :
                     mem_write ? OP_WR   : OP_NONE;
    assign accept  = (state_q == IDLE) && req;

    // With zero wait states acceptance and commit share one edge, so the commit must
    // use the live inputs rather than the request registers still being loaded.
    assign commit    = (state_d == RESP);
    assign cmt_op    = (state_q == IDLE) ? acc_op : op_q;
    assign cmt_idx   = (state_q == IDLE) ? addr[ADDR_W+1:2] : idx_q;
    assign cmt_wdata = (state_q == IDLE) ? wdata : wdata_q;

    mips_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && (cmt_op == OP_WR)),
        .idx   (cmt_idx),
        .wdata (cmt_wdata),
        .rdata (arr_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    cnt_d   = CNT_W'(WAIT_INIT);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request registers and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NONE;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= acc_op;
                idx_q   <= addr[ADDR_W+1:2];
                wdata_q <= wdata;
                err_q   <= acc_err;
            end
            if (commit && (cmt_op == OP_RD)) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    // Outputs decoded from state only
    always_comb begin
        mem_ready = (state_q == RESP);
        mem_err   = (state_q == RESP) && err_q;
        busy      = (state_q != IDLE);
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: one instance with two wait states (index 0) and one with
// none (index 1). Expected responses come from a small memory model and sit in a queue
// until the instance answers.
module tb_mips_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rd_s, wr_s;
    logic [31:0] addr_s [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic [1:0]  ready_s, err_s, busy_s;

    exp_t        sb_q [$];
    logic [31:0] model_mem [2][256];
    logic [31:0] model_rdata [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mips_mem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (rd_s[0]),
        .mem_write (wr_s[0]),
        .addr      (addr_s[0]),
        .wdata     (wdata_s[0]),
        .rdata     (rdata_s[0]),
        .mem_ready (ready_s[0]),
        .mem_err   (err_s[0]),
        .busy      (busy_s[0])
    );

    mips_mem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (rd_s[1]),
        .mem_write (wr_s[1]),
        .addr      (addr_s[1]),
        .wdata     (wdata_s[1]),
        .rdata     (rdata_s[1]),
        .mem_ready (ready_s[1]),
        .mem_err   (err_s[1]),
        .busy      (busy_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on instance s, entered just after a rising edge (cycle 0). With scramble
    // set, addr/wdata are changed to sc_addr/sc_data during the first wait cycle.
    task automatic access(input string tag, input int s, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, input logic [31:0] sc_addr,
                          input logic [31:0] sc_data);
        exp_t e;
        exp_t got_e;
        int   idx;
        int   cyc;
        int   lat;
        bit   got;
        idx   = int'(a[9:2]);
        e.err = r & w;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e.err = 1'b1;
`endif
        if (!e.err && r) model_rdata[s] = model_mem[s][idx];
        if (!e.err && w) model_mem[s][idx] = d;
        e.rdata = model_rdata[s];
        sb_q.push_back(e);
        lat = (s == 0) ? 3 : 1;

        rd_s[s] = r; wr_s[s] = w; addr_s[s] = a; wdata_s[s] = d;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (ready_s[s]) begin
                got   = 1;
                got_e = sb_q.pop_front();
                check({tag, "_lat"}, cyc, lat);
                check({tag, "_rdata"}, rdata_s[s], got_e.rdata);
                check({tag, "_err"}, {31'd0, err_s[s]}, {31'd0, got_e.err});
                check({tag, "_busy"}, {31'd0, busy_s[s]}, 32'd1);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && cyc == 1) begin
                addr_s[s] = sc_addr;
                wdata_s[s] = sc_data;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        rd_s[s] = 1'b0; wr_s[s] = 1'b0;
        // rdata must hold in the idle cycle after the response
        @(negedge clk);
        check({tag, "_hold"}, rdata_s[s], model_rdata[s]);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input int s, input logic [31:0] a, input logic [31:0] d);
        access(tag, s, 1'b0, 1'b1, a, d, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd(input string tag, input int s, input logic [31:0] a);
        access(tag, s, 1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rdat;
        rd_s = '0; wr_s = '0;
        for (int s = 0; s < 2; s++) begin
            addr_s[s] = '0; wdata_s[s] = '0; model_rdata[s] = '0;
        end

        // Reset values
        #12;
        for (int s = 0; s < 2; s++) begin
            check("rst_rdata", rdata_s[s], 32'd0);
            check("rst_ready", {31'd0, ready_s[s]}, 32'd0);
            check("rst_err", {31'd0, err_s[s]}, 32'd0);
            check("rst_busy", {31'd0, busy_s[s]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write/read, and address wrap above the memory size
        wr("wr10", 0, 32'h10, 32'hDEADBEEF);
        rd("rd10", 0, 32'h10);
        rd("rd410_wrap", 0, 32'h410);

        // Zero wait states
        wr("z_wr0", 1, 32'h0, 32'hCAFEF00D);
        rd("z_rd0", 1, 32'h0);
        access("z_conflict", 1, 1'b1, 1'b1, 32'h0, 32'h01234567, 1'b0, 32'd0, 32'd0);
        rd("z_rd0_after", 1, 32'h0);

        // Inputs changed after acceptance are ignored
        wr("pre24", 0, 32'h24, 32'hAAAA5555);
        access("wr20_scr", 0, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h24, 32'h00000BAD);
        rd("rd20", 0, 32'h20);
        rd("rd24", 0, 32'h24);

        // Read/write conflict
        wr("pre30", 0, 32'h30, 32'h0BADF00D);
        rd("rd10_b", 0, 32'h10);
        access("conflict30", 0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0);
        rd("rd30", 0, 32'h30);

        // Asynchronous reset in the middle of a wait state drops the uncommitted write
        wr("pre40", 0, 32'h40, 32'h11111111);
        wr_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'h99999999;
        @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy_s[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdata", rdata_s[0], 32'd0);
        check("arst_ready", {31'd0, ready_s[0]}, 32'd0);
        check("arst_err", {31'd0, err_s[0]}, 32'd0);
        check("arst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("arst_rdata0", rdata_s[1], 32'd0);
        wr_s[0] = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd("rd40_after_rst", 0, 32'h40);

        // Misaligned write to 0x42 (word index 0x10)
        wr("wr42", 0, 32'h42, 32'h5A5A5A5A);
        rd("rd40_w10", 0, 32'h40);

        // Random write-then-read pairs on both instances
        for (int i = 0; i < 6; i++) begin
            ra   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rdat = $urandom;
            wr("rnd_wr", i % 2, ra, rdat);
            rd("rnd_rd", i % 2, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
